z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Synchronous target-side responder for the Z80 external bus: watches the CPU's control strobes, address and data pins, and services memory, I/O and interrupt-acknowledge cycles. It issues single-transaction requests to a local memory/peripheral port, stretches CPU cycles with nWAIT until data is ready, drives read data and IM2 vectors onto the data bus, and raises nINT. It sits outside the CPU core on the same clock, as the slave end of the pin interface.

## Interface
- MEM_WAIT, 0: extra nWAIT cycles after bus_ack on memory reads (0..15).
- IO_WAIT, 1: extra nWAIT cycles after bus_ack on I/O reads (0..15).
- clk  in  1  same clock as CPU CLK; all sampling on rising edge.
- reset  in  1  asynchronous, active-high.
- A  in  16  CPU address pins.
- D_in  in  8  CPU data pins (write data).
- D_out  out  8  data driven to CPU.
- D_oe  out  1  D_out output enable.
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU control strobes, active-low.
- nWAIT  out  1  wait request to CPU, active-low, registered.
- nINT  out  1  interrupt request to CPU, active-low, registered.
- bus_req  out  1  local transaction request; held until bus_ack.
- bus_io  out  1  1 = I/O space, 0 = memory.
- bus_we  out  1  1 = write.
- bus_addr  out  16  latched A.
- bus_wdata  out  8  latched D_in.
- bus_rdata  in  8  read data, valid with bus_ack.
- bus_ack  in  1  single-cycle completion pulse.
- irq  in  1  level interrupt request from peripherals.
- irq_vector  in  8  IM2 vector byte.

## Operation
- Cycle classification at sampling edge (state IDLE): MRD = ~nMREQ & nRFSH & ~nRD; MWR = ~nMREQ & nRFSH & ~nWR; IORD = ~nIORQ & nM1 & ~nRD; IOWR = ~nIORQ & nM1 & ~nWR; INTA = ~nIORQ & ~nM1. nMREQ low with nRFSH low (refresh) is ignored. nMREQ low with nRD and nWR both high: stay IDLE.
- States: IDLE, RDREQ, RDWAIT, DRIVE, WRPOST, INTA, DONE.
- MRD/IORD: latch A, set bus_req=1, bus_we=0, bus_io per class, nWAIT=0; -> RDREQ. On bus_ack: capture bus_rdata into D_out, bus_req=0; load wait counter with MEM_WAIT/IO_WAIT; if 0 -> DRIVE (nWAIT=1) else RDWAIT. RDWAIT decrements each cycle; at 1 -> DRIVE, nWAIT=1.
- DRIVE: D_oe=1 while nRD low; when nRD sampled high, D_oe=0 -> IDLE.
- MWR/IOWR: latch A and D_in, bus_req=1, bus_we=1; writes are posted, nWAIT stays 1; -> WRPOST, which waits for the strobe (nWR) to rise -> IDLE, with bus_req remaining high independently until bus_ack.
- Read or write detected while a posted write is still unacknowledged: hold nWAIT=0 and do not start the new request until bus_ack of the posted write; then proceed as above in the following cycle.
- INTA: latch irq_vector into D_out, D_oe=1 until nIORQ sampled high -> IDLE. No bus_req.
- nINT = ~irq registered one cycle.
- DONE: any strobe still low after completion waits here until nRD, nWR and nIORQ are all high (prevents double service).

## Timing
- Reset values: nWAIT=1, nINT=1, D_oe=0, D_out=8'h00, bus_req=0, bus_we=0, bus_io=0, bus_addr=16'h0000, bus_wdata=8'h00; state IDLE.
- nWAIT falls on the edge after the strobe is first sampled (rising T2 for MRD), so the CPU sees it at falling T2.
- Read latency: bus_ack at edge N -> D_out valid and nWAIT high at N+1+wait count.
- bus_ack while bus_req=0: ignored.
- Reset mid-cycle: all outputs return to reset values immediately; a late bus_ack is ignored.
- Wait counter is 4 bits; parameters above 15 are a configuration error.

## Configuration
- RESP_INTA_EN defined: INTA class, irq_vector drive and nINT generation present.
- Undefined: nINT tied to 1, INTA cycles ignored (D_oe stays 0), irq/irq_vector unused.

## Test plan
- MRD at A=16'h1234, bus_ack 3 cycles later with bus_rdata=8'hA5, MEM_WAIT=0 -> nWAIT low 3 cycles, D_out=8'hA5 with D_oe=1 until nRD rises.
- IORD with IO_WAIT=2 -> bus_io=1, nWAIT released exactly 2 cycles after bus_ack.
- MWR 8'h5A to 16'h8000, ack delayed 6 cycles, followed by M1 fetch -> nWAIT low on fetch until write ack, then fetch request issued.
- Refresh (nMREQ & nRFSH low) -> no bus_req, nWAIT stays 1.
- RESP_INTA_EN: irq=1, vector 8'hFE -> nINT low next cycle; INTA cycle drives 8'hFE, D_oe drops when nIORQ rises.
- Reset asserted in RDREQ then ack pulsed -> all outputs at reset values, ack ignored, next MRD serviced normally.

Source files
------------

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 external-bus target servicing memory, I/O and interrupt-acknowledge cycles
//
// Purpose: classifies CPU bus cycles from the active-low strobes, turns each
// memory/I/O access into one request on the local bus port, and stretches the
// CPU with nWAIT until read data is ready. Writes are posted, so the CPU is not
// held for them. A new access that arrives while a posted write is still
// outstanding is held with nWAIT until that write completes.
//
// Ports:
//   clk, reset                 CPU clock; asynchronous active-high reset
//   A, D_in                    CPU address and write-data pins
//   D_out, D_oe                data driven back to the CPU and its enable
//   nM1 nMREQ nIORQ nRD nWR nRFSH  CPU control strobes (active-low)
//   nWAIT, nINT                registered wait and interrupt requests (active-low)
//   bus_req/io/we/addr/wdata   local request, held until bus_ack
//   bus_rdata, bus_ack         local read data and single-cycle completion
//   irq, irq_vector            peripheral interrupt level and IM2 vector
//
// Parameters: MEM_WAIT / IO_WAIT = extra nWAIT cycles after bus_ack on
// memory / I/O reads (0..15).
// Macro RESP_INTA_EN: when defined, interrupt-acknowledge cycles are serviced
// with irq_vector and nINT follows irq; otherwise nINT is held high.

module z80_bus_responder #(
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic        nINT,
    output logic        bus_req,
    output logic        bus_io,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    input  logic        irq,
    input  logic [7:0]  irq_vector
);

    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_RDREQ, S_RDWAIT, S_DRIVE, S_WRPOST, S_INTA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nwait_q, nwait_d;
    logic        nint_q, nint_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_io_q, bus_io_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;

    // Refresh cycles (nRFSH low) never qualify as memory accesses.
    logic is_mrd, is_mwr, is_iord, is_iowr, is_rd, is_wr, all_high, ack_v;
    logic [3:0] wait_load;
    assign is_mrd    = ~nMREQ & nRFSH & ~nRD;
    assign is_mwr    = ~nMREQ & nRFSH & ~nWR;
    assign is_iord   = ~nIORQ & nM1 & ~nRD;
    assign is_iowr   = ~nIORQ & nM1 & ~nWR;
    assign is_rd     = is_mrd | is_iord;
    assign is_wr     = is_mwr | is_iowr;
    assign all_high  = nRD & nWR & nIORQ;
    assign ack_v     = bus_req_q & bus_ack;     // stray acks are ignored
    assign wait_load = bus_io_q ? IO_W : MEM_W;

`ifdef RESP_INTA_EN
    logic is_inta;
    assign is_inta = ~nIORQ & ~nM1;
`else
    logic unused_inta;
    assign unused_inta = ^{irq, irq_vector};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nwait_d     = nwait_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        bus_req_d   = bus_req_q;
        bus_io_d    = bus_io_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
`ifdef RESP_INTA_EN
        nint_d      = ~irq;
`else
        nint_d      = 1'b1;
`endif
        // The request drops on its ack in any state, so a posted write can
        // complete while the CPU has already moved on.
        if (ack_v) begin
            bus_req_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
`ifdef RESP_INTA_EN
                if (is_inta) begin
                    d_out_d = irq_vector;
                    d_oe_d  = 1'b1;
                    state_d = S_INTA;
                end else
`endif
                if (is_rd || is_wr) begin
                    if (bus_req_q) begin
                        // Posted write still outstanding: stall the CPU and
                        // start this access the cycle after its ack.
                        nwait_d = 1'b0;
                    end else begin
                        bus_req_d  = 1'b1;
                        bus_addr_d = A;
                        bus_io_d   = is_rd ? is_iord : is_iowr;
                        if (is_rd) begin
                            bus_we_d = 1'b0;
                            nwait_d  = 1'b0;
                            state_d  = S_RDREQ;
                        end else begin
                            bus_we_d    = 1'b1;
                            bus_wdata_d = D_in;
                            nwait_d     = 1'b1;
                            state_d     = S_WRPOST;
                        end
                    end
                end
            end
            S_RDREQ: begin
                if (ack_v) begin
                    d_out_d = bus_rdata;
                    cnt_d   = wait_load;
                    if (wait_load == 4'd0) begin
                        nwait_d = 1'b1;
                        d_oe_d  = 1'b1;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    nwait_d = 1'b1;
                    d_oe_d  = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (nRD) begin
                    d_oe_d  = 1'b0;
                    state_d = all_high ? S_IDLE : S_DONE;
                end
            end
            S_WRPOST: begin
                if (nWR) begin
                    state_d = all_high ? S_IDLE : S_DONE;
                end
            end
            S_INTA: begin
                if (nIORQ) begin
                    d_oe_d  = 1'b0;
                    state_d = all_high ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (all_high) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            nwait_q     <= 1'b1;
            nint_q      <= 1'b1;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_io_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nwait_q     <= nwait_d;
            nint_q      <= nint_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            bus_req_q   <= bus_req_d;
            bus_io_q    <= bus_io_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign nWAIT     = nwait_q;
    assign nINT      = nint_q;
    assign D_out     = d_out_q;
    assign D_oe      = d_oe_q;
    assign bus_req   = bus_req_q;
    assign bus_io    = bus_io_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - self-checking bench for z80_bus_responder

module tb_z80_bus_responder;

    localparam int MW = 0;
    localparam int IW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        nM1 = 1'b1, nMREQ = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nRFSH = 1'b1;
    logic        nWAIT, nINT;
    logic        bus_req, bus_io, bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_ack = 1'b0;
    logic        irq = 1'b0;
    logic [7:0]  irq_vector = 8'h00;

    z80_bus_responder #(.MEM_WAIT(MW), .IO_WAIT(IW)) dut (
        .clk(clk), .reset(reset), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .nWAIT(nWAIT), .nINT(nINT), .bus_req(bus_req), .bus_io(bus_io), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .irq(irq), .irq_vector(irq_vector)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;            // edge k is the rising edge just before negedge k
    int ack_lat = 0;        // extra cycles the local port takes before acking
    bit resp_en = 1'b1;
    bit busy = 1'b0;
    int rcnt = 0;
    logic [7:0] rdata_next = 8'h00;
    int pend_ack_edge = -100;  // edge at which the last posted write is acked

    // Advance to the next falling edge and act as the local memory port.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus_ack = 1'b0;
        if (resp_en) begin
            if (bus_req && !busy) begin
                busy = 1'b1;
                rcnt = ack_lat;
            end
            if (busy) begin
                if (rcnt == 0) begin
                    bus_rdata = rdata_next;
                    bus_ack   = 1'b1;
                    busy      = 1'b0;
                end else begin
                    rcnt--;
                end
            end
        end
    endtask

    task automatic strobes_idle();
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    endtask

    // A read starts at the first sampling edge, or one edge after an
    // outstanding write is acked; nWAIT stays low until ack + wait count.
    task automatic do_read(input bit io, input bit m1, input logic [15:0] addr,
                           input logic [7:0] data, input int lat, input string tag);
        int s, r, rel, lowc, expw;
        ack_lat    = lat;
        rdata_next = data;
        s    = cyc + 1;
        r    = (pend_ack_edge >= s) ? pend_ack_edge + 1 : s;
        rel  = r + lat + 1 + (io ? IW : MW);
        expw = rel - s;
        A = addr;
        nM1 = m1 ? 1'b0 : 1'b1;
        if (io) nIORQ = 1'b0; else nMREQ = 1'b0;
        nRD = 1'b0;
        tick();
        lowc = 0;
        while (nWAIT === 1'b0 && lowc < 60) begin
            lowc++;
            tick();
        end
        tests++;
        if (lowc != expw) begin
            fails++;
            $display("FAIL %s nwait_low_cycles got %0d expected %0d", tag, lowc, expw);
        end
        tests++;
        if (D_out !== data || D_oe !== 1'b1) begin
            fails++;
            $display("FAIL %s data got %h oe=%b expected %h oe=1", tag, D_out, D_oe, data);
        end
        tests++;
        if (bus_addr !== addr || bus_io !== io || bus_we !== 1'b0) begin
            fails++;
            $display("FAIL %s request got addr=%h io=%b we=%b expected addr=%h io=%b we=0",
                     tag, bus_addr, bus_io, bus_we, addr, io);
        end
        tick();
        tests++;
        if (D_oe !== 1'b1) begin
            fails++;
            $display("FAIL %s oe_hold got %b expected 1", tag, D_oe);
        end
        strobes_idle();
        tick();
        tests++;
        if (D_oe !== 1'b0) begin
            fails++;
            $display("FAIL %s oe_release got %b expected 0", tag, D_oe);
        end
    endtask

    task automatic do_write(input bit io, input logic [15:0] addr, input logic [7:0] data,
                            input int lat, input string tag);
        int s, r, lowc, expw;
        ack_lat = lat;
        s    = cyc + 1;
        r    = (pend_ack_edge >= s) ? pend_ack_edge + 1 : s;
        expw = r - s;
        pend_ack_edge = r + lat + 1;
        A = addr;
        D_in = data;
        if (io) nIORQ = 1'b0; else nMREQ = 1'b0;
        nWR = 1'b0;
        tick();
        lowc = 0;
        while (nWAIT === 1'b0 && lowc < 60) begin
            lowc++;
            tick();
        end
        tests++;
        if (lowc != expw) begin
            fails++;
            $display("FAIL %s nwait_low_cycles got %0d expected %0d", tag, lowc, expw);
        end
        tests++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_io !== io ||
            bus_addr !== addr || bus_wdata !== data) begin
            fails++;
            $display("FAIL %s request got req=%b we=%b io=%b addr=%h wdata=%h expected 1 1 %b %h %h",
                     tag, bus_req, bus_we, bus_io, bus_addr, bus_wdata, io, addr, data);
        end
        strobes_idle();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bus_req === 1'b1 || busy) && n < 40) begin
            n++;
            tick();
        end
        tick();
        tests++;
        if (bus_req !== 1'b0) begin
            fails++;
            $display("FAIL drain bus_req got %b expected 0", bus_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        strobes_idle();
        tick();
        tick();
        tests++;
        if ({nWAIT, nINT, D_oe, bus_req, bus_we, bus_io} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_ctrl got %b expected 110000", {nWAIT, nINT, D_oe, bus_req, bus_we, bus_io});
        end
        tests++;
        if ({D_out, bus_addr, bus_wdata} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data got %h expected 0", {D_out, bus_addr, bus_wdata});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reads();
        do_read(1'b0, 1'b0, 16'h1234, 8'hA5, 2, "mrd_1234");
        do_read(1'b1, 1'b0, 16'h0042, 8'h3C, 1, "iord_wait2");
        do_read(1'b0, 1'b1, 16'h0000, 8'hFF, 0, "m1_fetch_fast");
        do_read(1'b1, 1'b0, 16'hFFFF, 8'h00, 0, "iord_fast");
    endtask

    task automatic test_write_then_fetch();
        do_write(1'b0, 16'h8000, 8'h5A, 5, "mwr_8000");
        do_read(1'b0, 1'b1, 16'h0100, 8'h77, 1, "fetch_after_mwr");
        do_write(1'b1, 16'h00FE, 8'h81, 3, "iowr_fe");
        do_write(1'b0, 16'h4000, 8'h12, 0, "mwr_after_iowr");
        drain();
    endtask

    task automatic test_refresh();
        nMREQ = 1'b0;
        nRFSH = 1'b0;
        tick();
        tick();
        tests++;
        if (bus_req !== 1'b0 || nWAIT !== 1'b1) begin
            fails++;
            $display("FAIL refresh got req=%b nwait=%b expected 0 1", bus_req, nWAIT);
        end
        nRFSH = 1'b1;
        tick();
        tests++;
        if (bus_req !== 1'b0 || nWAIT !== 1'b1) begin
            fails++;
            $display("FAIL mreq_no_strobe got req=%b nwait=%b expected 0 1", bus_req, nWAIT);
        end
        strobes_idle();
        tick();
    endtask

    task automatic test_inta();
        irq_vector = 8'hFE;
        irq = 1'b1;
        tick();
        tests++;
`ifdef RESP_INTA_EN
        if (nINT !== 1'b0) begin
            fails++;
            $display("FAIL nint_assert got %b expected 0", nINT);
        end
`else
        if (nINT !== 1'b1) begin
            fails++;
            $display("FAIL nint_tied got %b expected 1", nINT);
        end
`endif
        nM1 = 1'b0;
        nIORQ = 1'b0;
        tick();
        tick();
        tests++;
`ifdef RESP_INTA_EN
        if (D_oe !== 1'b1 || D_out !== 8'hFE || bus_req !== 1'b0) begin
            fails++;
            $display("FAIL inta_drive got oe=%b d=%h req=%b expected 1 fe 0", D_oe, D_out, bus_req);
        end
`else
        if (D_oe !== 1'b0 || bus_req !== 1'b0 || nWAIT !== 1'b1) begin
            fails++;
            $display("FAIL inta_ignored got oe=%b req=%b nwait=%b expected 0 0 1", D_oe, bus_req, nWAIT);
        end
`endif
        strobes_idle();
        irq = 1'b0;
        tick();
        tests++;
        if (D_oe !== 1'b0 || nINT !== 1'b1) begin
            fails++;
            $display("FAIL inta_end got oe=%b nint=%b expected 0 1", D_oe, nINT);
        end
    endtask

    task automatic test_reset_mid();
        ack_lat = 10;
        A = 16'h2222;
        nMREQ = 1'b0;
        nRD = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        resp_en = 1'b0;
        busy = 1'b0;
        #1;
        tests++;
        if ({nWAIT, nINT, D_oe, bus_req, bus_we, bus_io} !== 6'b110000 ||
            {D_out, bus_addr, bus_wdata} !== 32'h0) begin
            fails++;
            $display("FAIL reset_async got ctrl=%b data=%h expected 110000 0",
                     {nWAIT, nINT, D_oe, bus_req, bus_we, bus_io}, {D_out, bus_addr, bus_wdata});
        end
        strobes_idle();
        tick();
        reset = 1'b0;
        bus_rdata = 8'h99;
        bus_ack = 1'b1;
        tick();
        tick();
        tests++;
        if ({nWAIT, D_oe, bus_req} !== 3'b100 || D_out !== 8'h00) begin
            fails++;
            $display("FAIL late_ack got nwait=%b oe=%b req=%b d=%h expected 1 0 0 00",
                     nWAIT, D_oe, bus_req, D_out);
        end
        resp_en = 1'b1;
        pend_ack_edge = -100;
        do_read(1'b0, 1'b0, 16'h2345, 8'hC3, 1, "mrd_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [15:0] addr;
            logic [7:0]  data;
            int          op;
            int          lat;
            addr = 16'($urandom);
            data = 8'($urandom);
            op   = int'($urandom_range(0, 3));
            lat  = int'($urandom_range(0, 4));
            case (op)
                0: do_read(1'b0, bit'($urandom_range(0, 1)), addr, data, lat, "rnd_mrd");
                1: do_read(1'b1, 1'b0, addr, data, lat, "rnd_iord");
                2: do_write(1'b0, addr, data, lat, "rnd_mwr");
                default: do_write(1'b1, addr, data, lat, "rnd_iowr");
            endcase
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_reads();
        test_write_then_fetch();
        test_refresh();
        test_inta();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
